reg_bank_arbiter: RTL and testbench
===================================

Name: reg_bank_arbiter

Overview:
Shares one bank of 16-bit registers between two requesters, A and B.
- Round-robin arbitration per cycle over a valid/ready request channel.
- Single write/read port into the bank; registered read responses.
- Sits between CPU-side masters (e.g. fetch/execute units) and the register storage built from REGISTER-style load-enabled words.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 8, number of registers in bank (power of two)
ADDR_W, 3, address width, equals log2(DEPTH)

Ports:
CLK  input  1  system clock, rising edge
RSTn  input  1  asynchronous active-low reset
A_VALID  input  1  requester A has a request
A_WE  input  1  1 = write, 0 = read
A_ADDR  input  ADDR_W  register index
A_WDATA  input  WIDTH  write data
A_READY  output  1  grant; transfer occurs when A_VALID & A_READY
A_RSP_VALID  output  1  read data valid for A
A_RDATA  output  WIDTH  read data for A
B_VALID, B_WE, B_ADDR, B_WDATA, B_READY, B_RSP_VALID, B_RDATA: same as A, for requester B
BUSY  output  1  any grant issued this cycle

Behaviour:
- Reset, asynchronous on RSTn low:
  - All bank registers = 0.
  - Priority pointer = A.
  - A_RSP_VALID = B_RSP_VALID = 0; A_RDATA = B_RDATA = 0.
  - Lock state = IDLE.
- READY is combinational from VALID and pointer. It is never asserted without VALID, and at most one READY is high per cycle.
- Arbitration:
  - Only one VALID high -> that requester is granted.
  - Both VALID high -> the requester named by the pointer is granted.
  - After any grant, the pointer moves to the other requester.
  - No grant -> pointer holds.
- A requester holds VALID, WE, ADDR and WDATA stable until READY. Dropping VALID before grant is legal; the request is withdrawn.
- Write: on a granted write, the bank word at ADDR takes WDATA at the next rising edge. There is no write response.
- Read:
  - Granted read in cycle t -> granted port's RSP_VALID = 1 in cycle t+1, RDATA = bank[ADDR] sampled at the edge ending cycle t.
  - RSP_VALID is a one-cycle pulse.
  - RDATA holds its last value when RSP_VALID = 0.
- Read-after-write: write granted in cycle t, read of the same address granted in t+1 -> returns the new data.
- There is no same-cycle bypass (only one grant per cycle).
- Back-to-back grants to the same requester are allowed only when the other requester is idle.
- Throughput: one transfer per cycle; no bubbles.
- Reset mid-operation: a pending response is dropped and all bank contents are cleared.

Optional Feature:
Macro: REG_BANK_ARB_LOCK_EN
- With the macro: adds ports A_LOCK and B_LOCK (input, 1 bit).
  - Lock FSM states: IDLE, LOCK_A, LOCK_B.
  - IDLE -> LOCK_x when x is granted with x_LOCK = 1.
  - While in LOCK_x, only x can be granted; the pointer is frozen.
  - LOCK_x -> IDLE on the first granted request from x with x_LOCK = 0. That request still completes.
  - A locked requester with VALID low holds the lock.
- Without the macro: no LOCK ports; pure round-robin; the FSM is absent.

Decomposition:
- Package reg_bank_arb_pkg holds:
  - WIDTH, DEPTH and ADDR_W defaults.
  - Requester-id enum (REQ_A, REQ_B).
  - Lock-state enum (IDLE, LOCK_A, LOCK_B).
- One sub-module, reg_bank:
  - DEPTH x WIDTH registers, one write port (WE, WADDR, WDATA), one combinational read port (RADDR -> RDATA).
  - Asynchronous active-low clear.
- The arbiter wraps reg_bank and holds the pointer, response registers and lock FSM.

Test Plan:
1. Reset, then A reads addr 5 -> A_RSP_VALID one cycle later, A_RDATA = 0x0000; B outputs idle.
2. A writes 0x1234 to addr 2, B writes 0xBEEF to addr 2 in the same cycle. Expect:
   - A granted first (pointer = A), B granted the next cycle.
   - A subsequent read of addr 2 returns 0xBEEF.
3. Both hold read requests continuously for 6 cycles -> grants alternate A, B, A, B, A, B; each RSP_VALID pulse is routed to the correct port.
4. B writes 0x00FF to addr 7 in cycle t, B reads addr 7 in t+1 (A idle) -> B_RDATA = 0x00FF in t+2; back-to-back grants to B.
5. RSTn pulsed low while a read response is pending -> RSP_VALID stays 0, and all registers read back 0x0000 afterwards.
6. With REG_BANK_ARB_LOCK_EN: A is granted with A_LOCK = 1, B holds VALID. Expect:
   - B is not granted during 3 further A transfers.
   - A releases with A_LOCK = 0 on its last transfer, and B is granted the next cycle.

Source files
------------

// File: rtl/reg_bank_arb_pkg.sv
// Shared defaults and enums for the two-requester register bank arbiter.
package reg_bank_arb_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } lock_state_e;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH load-enabled register bank: one write port and one
// combinational read port, cleared asynchronously on rst_ni low.
module reg_bank
  import reg_bank_arb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] memQ [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        memQ[i] <= '0;
      end
    end else if (we_i) begin
      memQ[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = memQ[raddr_i];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing one reg_bank between requesters A and B.
// Define REG_BANK_ARB_LOCK_EN to add A_LOCK/B_LOCK and the lock FSM.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              A_VALID,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [WIDTH-1:0]  A_WDATA,
  output logic              A_READY,
  output logic              A_RSP_VALID,
  output logic [WIDTH-1:0]  A_RDATA,
  input  logic              B_VALID,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [WIDTH-1:0]  B_WDATA,
  output logic              B_READY,
  output logic              B_RSP_VALID,
  output logic [WIDTH-1:0]  B_RDATA,
`ifdef REG_BANK_ARB_LOCK_EN
  input  logic              A_LOCK,
  input  logic              B_LOCK,
`endif
  output logic              BUSY
);

  req_id_e           ptrQ, ptrD;
  logic              grantA, grantB;
  logic              lockedA, lockedB;
  logic              bankWe;
  logic [ADDR_W-1:0] bankAddr;
  logic [WIDTH-1:0]  bankWdata, bankRdata;
  logic              aRspValidQ, bRspValidQ;
  logic [WIDTH-1:0]  aRdataQ, bRdataQ;

`ifdef REG_BANK_ARB_LOCK_EN
  lock_state_e lockQ, lockD;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lockQ <= IDLE;
    else       lockQ <= lockD;
  end

  // A lock is taken on a granted locked request and dropped by the owner's
  // first granted unlocked request; an idle owner keeps the lock.
  always_comb begin
    lockD = lockQ;
    case (lockQ)
      IDLE: begin
        if (grantA && A_LOCK)      lockD = LOCK_A;
        else if (grantB && B_LOCK) lockD = LOCK_B;
      end
      LOCK_A:  if (grantA && !A_LOCK) lockD = IDLE;
      LOCK_B:  if (grantB && !B_LOCK) lockD = IDLE;
      default: lockD = IDLE;
    endcase
  end

  assign lockedA = (lockQ == LOCK_A);
  assign lockedB = (lockQ == LOCK_B);
`else
  assign lockedA = 1'b0;
  assign lockedB = 1'b0;
`endif

  assign grantA = A_VALID & (lockedA | (~lockedB & (~B_VALID | (ptrQ == REQ_A))));
  assign grantB = B_VALID & (lockedB | (~lockedA & (~A_VALID | (ptrQ == REQ_B))));

  assign A_READY = grantA;
  assign B_READY = grantB;
  assign BUSY    = grantA | grantB;

  // The pointer names the loser of the last grant and freezes under a lock.
  always_comb begin
    ptrD = ptrQ;
    if (!(lockedA || lockedB)) begin
      if (grantA)      ptrD = REQ_B;
      else if (grantB) ptrD = REQ_A;
    end
  end

  assign bankWe    = (grantA & A_WE) | (grantB & B_WE);
  assign bankAddr  = grantB ? B_ADDR  : A_ADDR;
  assign bankWdata = grantB ? B_WDATA : A_WDATA;

  reg_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .we_i    (bankWe),
    .waddr_i (bankAddr),
    .wdata_i (bankWdata),
    .raddr_i (bankAddr),
    .rdata_o (bankRdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptrQ       <= REQ_A;
      aRspValidQ <= 1'b0;
      bRspValidQ <= 1'b0;
      aRdataQ    <= '0;
      bRdataQ    <= '0;
    end else begin
      ptrQ       <= ptrD;
      aRspValidQ <= grantA & ~A_WE;
      bRspValidQ <= grantB & ~B_WE;
      if (grantA && !A_WE) aRdataQ <= bankRdata;
      if (grantB && !B_WE) bRdataQ <= bankRdata;
    end
  end

  assign A_RSP_VALID = aRspValidQ;
  assign A_RDATA     = aRdataQ;
  assign B_RSP_VALID = bRspValidQ;
  assign B_RDATA     = bRdataQ;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter; the lock scenario runs only when
// REG_BANK_ARB_LOCK_EN is defined.
module tb_reg_bank_arbiter;

  logic        CLK;
  logic        RSTn;
  logic        A_VALID, A_WE, B_VALID, B_WE;
  logic [2:0]  A_ADDR, B_ADDR;
  logic [15:0] A_WDATA, B_WDATA;
  logic        A_READY, A_RSP_VALID, B_READY, B_RSP_VALID, BUSY;
  logic [15:0] A_RDATA, B_RDATA;
`ifdef REG_BANK_ARB_LOCK_EN
  logic        A_LOCK, B_LOCK;
`endif

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .A_VALID     (A_VALID),
    .A_WE        (A_WE),
    .A_ADDR      (A_ADDR),
    .A_WDATA     (A_WDATA),
    .A_READY     (A_READY),
    .A_RSP_VALID (A_RSP_VALID),
    .A_RDATA     (A_RDATA),
    .B_VALID     (B_VALID),
    .B_WE        (B_WE),
    .B_ADDR      (B_ADDR),
    .B_WDATA     (B_WDATA),
    .B_READY     (B_READY),
    .B_RSP_VALID (B_RSP_VALID),
    .B_RDATA     (B_RDATA),
`ifdef REG_BANK_ARB_LOCK_EN
    .A_LOCK      (A_LOCK),
    .B_LOCK      (B_LOCK),
`endif
    .BUSY        (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic awe, input logic [2:0] aaddr,
                               input logic [15:0] awdata, input logic bv, input logic bwe,
                               input logic [2:0] baddr, input logic [15:0] bwdata);
    A_VALID = av;  A_WE = awe;  A_ADDR = aaddr;  A_WDATA = awdata;
    B_VALID = bv;  B_WE = bwe;  B_ADDR = baddr;  B_WDATA = bwdata;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseReset();
    RSTn = 1'b0;
    #2;
    RSTn = 1'b1;
  endtask

  logic expA;

  initial begin
    RSTn = 1'b0;
`ifdef REG_BANK_ARB_LOCK_EN
    A_LOCK = 1'b0;
    B_LOCK = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_a_rsp_valid", 16'(A_RSP_VALID), 16'h0);
    checkOutput("rst_b_rsp_valid", 16'(B_RSP_VALID), 16'h0);
    checkOutput("rst_a_rdata", A_RDATA, 16'h0);
    checkOutput("rst_b_rdata", B_RDATA, 16'h0);
    checkOutput("rst_busy", 16'(BUSY), 16'h0);
    #10;
    RSTn = 1'b1;
    nextCycle();

    // 1: A reads addr 5 after reset
    applyStimulus(1, 0, 3'd5, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t1_a_ready", 16'(A_READY), 16'h1);
    checkOutput("t1_b_ready", 16'(B_READY), 16'h0);
    checkOutput("t1_busy", 16'(BUSY), 16'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_a_rsp_valid", 16'(A_RSP_VALID), 16'h1);
    checkOutput("t1_a_rdata", A_RDATA, 16'h0000);
    checkOutput("t1_b_rsp_valid", 16'(B_RSP_VALID), 16'h0);
    #1;
    checkOutput("t1_idle_busy", 16'(BUSY), 16'h0);
    nextCycle();
    checkOutput("t1_pulse_end", 16'(A_RSP_VALID), 16'h0);

    // 2: simultaneous writes to addr 2 from fresh reset pointer
    pulseReset();
    applyStimulus(1, 1, 3'd2, 16'h1234, 1, 1, 3'd2, 16'hBEEF);
    #1;
    checkOutput("t2_a_first", 16'(A_READY), 16'h1);
    checkOutput("t2_b_wait", 16'(B_READY), 16'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 3'd2, 16'hBEEF);
    #1;
    checkOutput("t2_b_second", 16'(B_READY), 16'h1);
    nextCycle();
    applyStimulus(1, 0, 3'd2, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_rsp_valid", 16'(A_RSP_VALID), 16'h1);
    checkOutput("t2_rdata", A_RDATA, 16'hBEEF);
    nextCycle();
    checkOutput("t2_hold_valid", 16'(A_RSP_VALID), 16'h0);
    checkOutput("t2_hold_rdata", A_RDATA, 16'hBEEF);

    // 3: B loads addr 3 (pointer back to A), then both read for 6 cycles
    applyStimulus(0, 0, 0, 0, 1, 1, 3'd3, 16'h5A5A);
    nextCycle();
    applyStimulus(1, 0, 3'd2, 0, 1, 0, 3'd3, 0);
    for (int i = 0; i < 6; i++) begin
      expA = (i % 2 == 0);
      #1;
      checkOutput($sformatf("t3_a_ready_%0d", i), 16'(A_READY), 16'(expA));
      checkOutput($sformatf("t3_b_ready_%0d", i), 16'(B_READY), 16'(!expA));
      nextCycle();
      if (i == 5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("t3_a_rsp_%0d", i), 16'(A_RSP_VALID), 16'(expA));
      checkOutput($sformatf("t3_b_rsp_%0d", i), 16'(B_RSP_VALID), 16'(!expA));
      if (expA) checkOutput($sformatf("t3_a_rdata_%0d", i), A_RDATA, 16'hBEEF);
      else      checkOutput($sformatf("t3_b_rdata_%0d", i), B_RDATA, 16'h5A5A);
    end

    // 4: B write then read-after-write to addr 7, back to back
    applyStimulus(0, 0, 0, 0, 1, 1, 3'd7, 16'h00FF);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 3'd7, 0);
    #1;
    checkOutput("t4_b_b2b_ready", 16'(B_READY), 16'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_b_rsp_valid", 16'(B_RSP_VALID), 16'h1);
    checkOutput("t4_b_rdata", B_RDATA, 16'h00FF);
    checkOutput("t4_a_rsp_valid", 16'(A_RSP_VALID), 16'h0);

    // 5: reset while A's read of addr 7 is pending, then scan the bank
    applyStimulus(1, 0, 3'd7, 0, 0, 0, 0, 0);
    #1;
    checkOutput("t5_a_ready", 16'(A_READY), 16'h1);
    RSTn = 1'b0;
    #1;
    checkOutput("t5_rsp_in_reset", 16'(A_RSP_VALID), 16'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("t5_rsp_after_edge", 16'(A_RSP_VALID), 16'h0);
    checkOutput("t5_b_rdata_clr", B_RDATA, 16'h0);
    RSTn = 1'b1;
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 3'(k), 0, 0, 0, 0, 0);
      nextCycle();
      checkOutput($sformatf("t5_scan_valid_%0d", k), 16'(A_RSP_VALID), 16'h1);
      checkOutput($sformatf("t5_scan_data_%0d", k), A_RDATA, 16'h0000);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

`ifdef REG_BANK_ARB_LOCK_EN
    // 6: A locks the bank for three further transfers while B waits
    pulseReset();
    applyStimulus(1, 0, 3'd1, 0, 1, 0, 3'd4, 0);
    A_LOCK = 1'b1;
    #1;
    checkOutput("t6_a_lock_grant", 16'(A_READY), 16'h1);
    nextCycle();
    for (int j = 0; j < 3; j++) begin
      A_LOCK = (j != 2);
      #1;
      checkOutput($sformatf("t6_a_ready_%0d", j), 16'(A_READY), 16'h1);
      checkOutput($sformatf("t6_b_blocked_%0d", j), 16'(B_READY), 16'h0);
      nextCycle();
    end
    A_LOCK = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0, 3'd4, 0);
    #1;
    checkOutput("t6_b_after_release", 16'(B_READY), 16'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_b_rsp_valid", 16'(B_RSP_VALID), 16'h1);
    nextCycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
